// File: rtl/riscv_ooo_pkg.sv
// Shared definitions for the out-of-order writeback path.
//   NUM_FU / CDB_PORTS : number of functional units and broadcast slots
//   FU_ALU0/ALU1/LSU   : functional-unit index constants
//   cdb_entry_t        : one buffered writeback {result, pc, tag}
//   fu_next()          : round-robin successor over the three FUs
package riscv_ooo_pkg;

    localparam int NUM_FU     = 3;
    localparam int CDB_PORTS  = 2;
    localparam int CDB_DATA_W = 32;
    localparam int CDB_TAG_W  = 6;

    localparam logic [1:0] FU_ALU0 = 2'd0;
    localparam logic [1:0] FU_ALU1 = 2'd1;
    localparam logic [1:0] FU_LSU  = 2'd2;

    typedef struct packed {
        logic [CDB_DATA_W-1:0] result;
        logic [CDB_DATA_W-1:0] pc;
        logic [CDB_TAG_W-1:0]  tag;
    } cdb_entry_t;

    function automatic logic [1:0] fu_next(input logic [1:0] idx);
        return (idx == FU_LSU) ? FU_ALU0 : idx + 2'd1;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO buffering one functional unit's writeback results.
//   clk, rst     : clock, synchronous active-high reset
//   flush        : drop every buffered entry (pointers return to zero)
//   enq/enq_data : write one entry when not full
//   deq          : retire the head entry when not empty
//   head         : current head entry (combinational view of storage)
//   full/empty   : status derived from the registered pointers only
module wb_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             enq,
    input  logic [WIDTH-1:0] enq_data,
    input  logic             deq,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    // One extra pointer bit tells a full FIFO apart from an empty one.
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic [WIDTH-1:0] mem [DEPTH];

    logic do_enq;
    logic do_deq;

    assign full   = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                    (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign empty  = (wr_ptr_reg == rd_ptr_reg);
    assign do_enq = enq && !full && !flush && !rst;
    assign do_deq = deq && !empty;
    assign head   = mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_enq) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_deq) rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    // Storage carries no reset; validity is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (do_enq) mem[wr_ptr_reg[AW-1:0]] <= enq_data;
    end

endmodule

// File: rtl/cdb_wb_arbiter.sv
// Writeback scheduler: three FU result FIFOs share two registered CDB slots.
//   clk, rst          : clock, synchronous active-high reset (beats flush_i)
//   flush_i           : mispredict flush, empties all FIFOs and the CDB slots
//   fu_valid_i/ready_o: per-FU handshake, ready = FIFO not full (0 in reset)
//   fuN_result/pc/tag : per-FU result payload
//   cdb_valid/src/result/pc/tag_o : two registered broadcast slots
// Build option: define LSU_PRIO_EN to give a nonempty LSU FIFO slot 0 every
// cycle, with FU0/FU1 sharing the remaining slot(s) round-robin.
// DATA_W/TAG_W must match the widths carried in cdb_entry_t.
module cdb_wb_arbiter
    import riscv_ooo_pkg::*;
#(
    parameter int DATA_W     = CDB_DATA_W,
    parameter int TAG_W      = CDB_TAG_W,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush_i,
    input  logic [2:0]                  fu_valid_i,
    output logic [2:0]                  fu_ready_o,
    input  logic [DATA_W-1:0]           fu0_result_i,
    input  logic [DATA_W-1:0]           fu0_pc_i,
    input  logic [TAG_W-1:0]            fu0_tag_i,
    input  logic [DATA_W-1:0]           fu1_result_i,
    input  logic [DATA_W-1:0]           fu1_pc_i,
    input  logic [TAG_W-1:0]            fu1_tag_i,
    input  logic [DATA_W-1:0]           fu2_result_i,
    input  logic [DATA_W-1:0]           fu2_pc_i,
    input  logic [TAG_W-1:0]            fu2_tag_i,
    output logic [1:0]                  cdb_valid_o,
    output logic [1:0][1:0]             cdb_src_o,
    output logic [1:0][DATA_W-1:0]      cdb_result_o,
    output logic [1:0][DATA_W-1:0]      cdb_pc_o,
    output logic [1:0][TAG_W-1:0]       cdb_tag_o
);

    cdb_entry_t             fu_entry [NUM_FU];
    cdb_entry_t             fifo_head [NUM_FU];
    logic [NUM_FU-1:0]      full;
    logic [NUM_FU-1:0]      empty;
    logic [NUM_FU-1:0]      enq;
    logic [NUM_FU-1:0]      deq;

    logic [1:0]             rr_reg;
    logic [1:0]             rr_next;
    logic [1:0]             grant_vld;
    logic [1:0][1:0]        grant_idx;

    assign fu_entry[0] = '{result: fu0_result_i, pc: fu0_pc_i, tag: fu0_tag_i};
    assign fu_entry[1] = '{result: fu1_result_i, pc: fu1_pc_i, tag: fu1_tag_i};
    assign fu_entry[2] = '{result: fu2_result_i, pc: fu2_pc_i, tag: fu2_tag_i};

    // Ready comes from registered fullness only, so a full FIFO refuses input
    // even in a cycle where its head is being granted.
    assign fu_ready_o = rst ? 3'b000 : ~full;
    assign enq        = fu_valid_i & fu_ready_o & {NUM_FU{!flush_i}};

    generate
        for (genvar gi = 0; gi < NUM_FU; gi++) begin : g_fifo
            wb_fifo #(
                .DEPTH (FIFO_DEPTH),
                .WIDTH ($bits(cdb_entry_t))
            ) u_fifo (
                .clk      (clk),
                .rst      (rst),
                .flush    (flush_i),
                .enq      (enq[gi]),
                .enq_data (fu_entry[gi]),
                .deq      (deq[gi]),
                .head     (fifo_head[gi]),
                .full     (full[gi]),
                .empty    (empty[gi])
            );
        end
    endgenerate

    always_comb begin
        logic [1:0] cand;
        logic [1:0] cnt;
        grant_vld = '0;
        grant_idx = '0;
        deq       = '0;
        rr_next   = rr_reg;
        cnt       = 2'd0;
`ifdef LSU_PRIO_EN
        if (!empty[FU_LSU]) begin
            grant_vld[0] = 1'b1;
            grant_idx[0] = FU_LSU;
            deq[FU_LSU]  = 1'b1;
            cnt          = 2'd1;
        end
        // rr_reg only ever holds FU_ALU0 or FU_ALU1 in this build.
        cand = {1'b0, rr_reg[0]};
        for (int k = 0; k < 2; k++) begin
            if (!empty[cand] && cnt < 2'(CDB_PORTS)) begin
                grant_vld[cnt[0]] = 1'b1;
                grant_idx[cnt[0]] = cand;
                deq[cand]         = 1'b1;
                rr_next           = (cand == FU_ALU0) ? FU_ALU1 : FU_ALU0;
                cnt               = cnt + 2'd1;
            end
            cand = {1'b0, ~cand[0]};
        end
`else
        cand = rr_reg;
        for (int k = 0; k < NUM_FU; k++) begin
            if (!empty[cand] && cnt < 2'(CDB_PORTS)) begin
                grant_vld[cnt[0]] = 1'b1;
                grant_idx[cnt[0]] = cand;
                deq[cand]         = 1'b1;
                rr_next           = fu_next(cand);
                cnt               = cnt + 2'd1;
            end
            cand = fu_next(cand);
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_reg       <= FU_ALU0;
            cdb_valid_o  <= '0;
            cdb_src_o    <= '0;
            cdb_result_o <= '0;
            cdb_pc_o     <= '0;
            cdb_tag_o    <= '0;
        end else if (flush_i) begin
            cdb_valid_o  <= '0;
            cdb_src_o    <= '0;
            cdb_result_o <= '0;
            cdb_pc_o     <= '0;
            cdb_tag_o    <= '0;
        end else begin
            rr_reg <= rr_next;
            for (int s = 0; s < CDB_PORTS; s++) begin
                cdb_valid_o[s]  <= grant_vld[s];
                cdb_src_o[s]    <= grant_vld[s] ? grant_idx[s] : 2'd0;
                cdb_result_o[s] <= grant_vld[s] ? fifo_head[grant_idx[s]].result : '0;
                cdb_pc_o[s]     <= grant_vld[s] ? fifo_head[grant_idx[s]].pc : '0;
                cdb_tag_o[s]    <= grant_vld[s] ? fifo_head[grant_idx[s]].tag : '0;
            end
        end
    end

endmodule

// File: tb/tb_cdb_wb_arbiter.sv
module tb_cdb_wb_arbiter;
    import riscv_ooo_pkg::*;

    localparam int DEPTH = 2;

    typedef struct packed {
        logic [1:0]       valid;
        logic [1:0][1:0]  src;
        logic [1:0][31:0] result;
        logic [1:0][31:0] pc;
        logic [1:0][5:0]  tag;
    } out_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             flush = 1'b0;
    logic [2:0]       fu_valid = 3'b000;
    logic [2:0]       fu_ready;
    logic [31:0]      res [3];
    logic [31:0]      pcv [3];
    logic [5:0]       tagv [3];
    logic [1:0]       cdb_valid;
    logic [1:0][1:0]  cdb_src;
    logic [1:0][31:0] cdb_result;
    logic [1:0][31:0] cdb_pc;
    logic [1:0][5:0]  cdb_tag;

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;

    // Reference model: per-FU queues of pending results and a round-robin pointer.
    cdb_entry_t fq [3][$];
    int         rr = 0;
    out_t       exp_q [$];

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 3; i++) begin
            res[i] = '0; pcv[i] = '0; tagv[i] = '0;
        end
    end

    cdb_wb_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (flush),
        .fu_valid_i   (fu_valid),
        .fu_ready_o   (fu_ready),
        .fu0_result_i (res[0]),
        .fu0_pc_i     (pcv[0]),
        .fu0_tag_i    (tagv[0]),
        .fu1_result_i (res[1]),
        .fu1_pc_i     (pcv[1]),
        .fu1_tag_i    (tagv[1]),
        .fu2_result_i (res[2]),
        .fu2_pc_i     (pcv[2]),
        .fu2_tag_i    (tagv[2]),
        .cdb_valid_o  (cdb_valid),
        .cdb_src_o    (cdb_src),
        .cdb_result_o (cdb_result),
        .cdb_pc_o     (cdb_pc),
        .cdb_tag_o    (cdb_tag)
    );

    function automatic void take(inout out_t e, inout int cnt, input int f);
        cdb_entry_t ent;
        ent = fq[f].pop_front();
        e.valid[cnt]  = 1'b1;
        e.src[cnt]    = 2'(f);
        e.result[cnt] = ent.result;
        e.pc[cnt]     = ent.pc;
        e.tag[cnt]    = ent.tag;
        cnt++;
    endfunction

    // Predicts the CDB contents after the coming edge from the inputs driven now.
    function automatic void model_step();
        out_t e;
        int   cnt;
        int   last;
        bit   rdy [3];
        e = '0;
        cnt = 0;
        last = -1;
        if (rst) begin
            for (int i = 0; i < 3; i++) fq[i].delete();
            rr = 0;
        end else if (flush) begin
            for (int i = 0; i < 3; i++) fq[i].delete();
        end else begin
            for (int i = 0; i < 3; i++) rdy[i] = fq[i].size() < DEPTH;
`ifdef LSU_PRIO_EN
            if (fq[2].size() > 0) take(e, cnt, 2);
            for (int k = 0; k < 2; k++) begin
                int f = (rr + k) % 2;
                if (fq[f].size() > 0 && cnt < 2) begin
                    take(e, cnt, f);
                    last = f;
                end
            end
            if (last >= 0) rr = (last + 1) % 2;
`else
            for (int k = 0; k < 3; k++) begin
                int f = (rr + k) % 3;
                if (fq[f].size() > 0 && cnt < 2) begin
                    take(e, cnt, f);
                    last = f;
                end
            end
            if (last >= 0) rr = (last + 1) % 3;
`endif
            for (int i = 0; i < 3; i++)
                if (fu_valid[i] && rdy[i])
                    fq[i].push_back('{result: res[i], pc: pcv[i], tag: tagv[i]});
        end
        exp_q.push_back(e);
    endfunction

    // One stimulus cycle: check ready, drive inputs, record expectation.
    task automatic step(input logic r, input logic f, input logic [2:0] v, input bit beef);
        logic [2:0] exp_rdy;
        @(negedge clk);
        cyc++;
        for (int i = 0; i < 3; i++) exp_rdy[i] = !rst && (fq[i].size() < DEPTH);
        n_vec++;
        if (fu_ready !== exp_rdy) begin
            n_bad++;
            $display("FAIL ready cyc=%0d got=%b exp=%b", cyc, fu_ready, exp_rdy);
        end
        rst = r;
        flush = f;
        fu_valid = v;
        for (int i = 0; i < 3; i++) begin
            res[i]  = $urandom;
            pcv[i]  = $urandom;
            tagv[i] = 6'($urandom);
        end
        if (beef) begin
            res[1]  = 32'hDEAD_BEEF;
            tagv[1] = 6'd5;
        end
        model_step();
    endtask

    // Monitor: compares every registered CDB cycle against the scoreboard.
    initial begin
        out_t e;
        out_t got;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                got.valid  = cdb_valid;
                got.src    = cdb_src;
                got.result = cdb_result;
                got.pc     = cdb_pc;
                got.tag    = cdb_tag;
                n_vec++;
                if (got !== e) begin
                    n_bad++;
                    $display("FAIL cdb t=%0t got v=%b src=%0d/%0d res=%h/%h tag=%0d/%0d exp v=%b src=%0d/%0d res=%h/%h tag=%0d/%0d",
                             $time, got.valid, got.src[0], got.src[1], got.result[0], got.result[1],
                             got.tag[0], got.tag[1], e.valid, e.src[0], e.src[1],
                             e.result[0], e.result[1], e.tag[0], e.tag[1]);
                end else begin
                    $display("cdb t=%0t v=%b src=%0d/%0d res=%h/%h tag=%0d/%0d",
                             $time, got.valid, got.src[0], got.src[1],
                             got.result[0], got.result[1], got.tag[0], got.tag[1]);
                end
            end
        end
    end

    initial begin
        // Reset held with all FUs asserting valid.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 3'b111, 1'b0);
        step(1'b0, 1'b0, 3'b000, 1'b0);
        step(1'b0, 1'b0, 3'b000, 1'b0);
        // Single FU1 result.
        step(1'b0, 1'b0, 3'b010, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 3'b000, 1'b0);
        // Three-way contention.
        step(1'b0, 1'b0, 3'b111, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 3'b000, 1'b0);
        // Saturation / back-pressure.
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 3'b111, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 3'b000, 1'b0);
        // Flush with loaded FIFOs and enqueues presented on the flush edge.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 3'b111, 1'b0);
        step(1'b0, 1'b0, 3'b101, 1'b0);
        step(1'b0, 1'b1, 3'b111, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 3'b000, 1'b0);
        // Randomized traffic with occasional flush and reset.
        for (int i = 0; i < 400; i++) begin
            logic [2:0] v;
            logic       f;
            logic       r;
            v = 3'($urandom);
            if ($urandom_range(0, 3) == 0) v = 3'b111;
            f = ($urandom_range(0, 24) == 0);
            r = ($urandom_range(0, 99) == 0);
            step(r, f, v, 1'b0);
        end
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 3'b000, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain got=%0d pending exp=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
